// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 1 << ADDR_W;

  // Requester index; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // One-entry write-back slot contents.
  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  // One-hot decode of a register address.
  function automatic logic [NREG-1:0] dec_addr(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back requesters, the arbiter and the register file.
// master: the requester / register-file side; slave: the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic              stall;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_BLOCK;
  logic [NREG-1:0]   pend_mask;

  modport master (
    output stall, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, WR_ADDR, WR_DATA, WR_BLOCK, pend_mask
  );

  modport slave (
    input  stall, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, WR_ADDR, WR_DATA, WR_BLOCK, pend_mask
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry write-back buffer: accepts a request when empty or when its current
// entry is granted on the same edge (reload), clears on a grant otherwise.
module wb_slot
  import regfile_wb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_ready,
  output logic              o_accept,
  output slot_t             o_slot
);

  slot_t r_slot;

  // Ready never looks at valid; a granted slot frees up on this edge.
  always_comb begin
    o_ready  = !i_reset && (!r_slot.full || i_grant);
    o_accept = i_valid && o_ready;
  end

  // Slot state: reset discards, accept loads (wins over clear), grant clears.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot <= '0;
    end else if (o_accept) begin
      r_slot <= '{full: 1'b1, addr: i_addr, data: i_data};
    end else if (i_grant) begin
      r_slot.full <= 1'b0;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and load write-back paths.
// Full slots are granted oldest first; same-age ties go to mem, or alternate
// when REGFILE_WB_RR_EN is defined. pend_mask covers buffered and presented writes.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
(
  input logic                 CLK,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  slot_t             w_alu_slot;
  slot_t             w_mem_slot;
  logic              w_alu_ready;
  logic              w_mem_ready;
  logic              w_alu_acc;
  logic              w_mem_acc;
  logic              w_gnt_alu;
  logic              w_gnt_mem;
  logic              w_alu_full_nx;
  logic              w_mem_full_nx;
  logic [NREG-1:0]   w_pend;

  // Age: r_age_diff=0 means both slots filled on the same edge (or not both full).
  logic              r_age_diff;
  logic              r_alu_older;
  logic              r_wr_block;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

`ifdef REGFILE_WB_RR_EN
  // Pointer holds the last tie winner; the other requester wins the next tie.
  req_e              r_rr_ptr;
  logic              w_tie;
`endif

  wb_slot u_alu_slot (
    .i_clk    (CLK),
    .i_reset  (reset),
    .i_valid  (bus.alu_valid),
    .i_addr   (bus.alu_addr),
    .i_data   (bus.alu_data),
    .i_grant  (w_gnt_alu),
    .o_ready  (w_alu_ready),
    .o_accept (w_alu_acc),
    .o_slot   (w_alu_slot)
  );

  wb_slot u_mem_slot (
    .i_clk    (CLK),
    .i_reset  (reset),
    .i_valid  (bus.mem_valid),
    .i_addr   (bus.mem_addr),
    .i_data   (bus.mem_data),
    .i_grant  (w_gnt_mem),
    .o_ready  (w_mem_ready),
    .o_accept (w_mem_acc),
    .o_slot   (w_mem_slot)
  );

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;

  // Grant selection: single full slot wins; both full -> older; same age -> tie-break.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_mem = 1'b0;
`ifdef REGFILE_WB_RR_EN
    w_tie     = 1'b0;
`endif
    if (!reset && !bus.stall) begin
      if (w_alu_slot.full && w_mem_slot.full) begin
        if (r_age_diff) begin
          w_gnt_alu = r_alu_older;
          w_gnt_mem = !r_alu_older;
        end else begin
`ifdef REGFILE_WB_RR_EN
          w_tie     = 1'b1;
          w_gnt_alu = (r_rr_ptr == REQ_MEM);
          w_gnt_mem = (r_rr_ptr == REQ_ALU);
`else
          w_gnt_mem = 1'b1;
`endif
        end
      end else if (w_alu_slot.full) begin
        w_gnt_alu = 1'b1;
      end else if (w_mem_slot.full) begin
        w_gnt_mem = 1'b1;
      end
    end
  end

  // Slot occupancy after this edge, used to update the age flag.
  always_comb begin
    w_alu_full_nx = w_alu_acc || (w_alu_slot.full && !w_gnt_alu);
    w_mem_full_nx = w_mem_acc || (w_mem_slot.full && !w_gnt_mem);
  end

  // Age tracking: a slot loaded on this edge is younger than one that stayed full.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_age_diff  <= 1'b0;
      r_alu_older <= 1'b0;
    end else if (w_alu_full_nx && w_mem_full_nx) begin
      if (w_alu_acc && w_mem_acc) begin
        r_age_diff  <= 1'b0;
        r_alu_older <= 1'b0;
      end else if (w_alu_acc) begin
        r_age_diff  <= 1'b1;
        r_alu_older <= 1'b0;
      end else if (w_mem_acc) begin
        r_age_diff  <= 1'b1;
        r_alu_older <= 1'b1;
      end
    end else begin
      r_age_diff  <= 1'b0;
      r_alu_older <= 1'b0;
    end
  end

`ifdef REGFILE_WB_RR_EN
  // Round-robin pointer advances only on tie-broken grants.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rr_ptr <= REQ_ALU;
    end else if (w_tie) begin
      r_rr_ptr <= w_gnt_mem ? REQ_MEM : REQ_ALU;
    end
  end
`endif

  // Write-port registers: present the winner, otherwise block and hold addr/data.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_block <= 1'b1;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else if (w_gnt_alu) begin
      r_wr_block <= 1'b0;
      r_wr_addr  <= w_alu_slot.addr;
      r_wr_data  <= w_alu_slot.data;
    end else if (w_gnt_mem) begin
      r_wr_block <= 1'b0;
      r_wr_addr  <= w_mem_slot.addr;
      r_wr_data  <= w_mem_slot.data;
    end else begin
      r_wr_block <= 1'b1;
    end
  end

  assign bus.WR_BLOCK = r_wr_block;
  assign bus.WR_ADDR  = r_wr_addr;
  assign bus.WR_DATA  = r_wr_data;

  // Pending mask: buffered destinations plus the write being presented now.
  always_comb begin
    w_pend = '0;
    if (w_alu_slot.full) w_pend = w_pend | dec_addr(w_alu_slot.addr);
    if (w_mem_slot.full) w_pend = w_pend | dec_addr(w_mem_slot.addr);
    if (!r_wr_block)     w_pend = w_pend | dec_addr(r_wr_addr);
  end

  assign bus.pend_mask = w_pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based model.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_live = 1'b0;
  bit         m_full [2];
  logic [2:0] m_addr [2];
  logic [7:0] m_data [2];
  int         m_stamp[2];
  int         m_cyc = 0;
  bit         m_blk;
  logic [2:0] m_wa;
  logic [7:0] m_wd;
  logic [7:0] m_rf [8];
  logic [7:0] tb_rf[8];
`ifdef REGFILE_WB_RR_EN
  int         m_last_tie;
`endif

  // Index 0 = alu, 1 = mem; -1 = no grant this cycle.
  function automatic int m_winner();
    if (reset || bus.stall) return -1;
    if (m_full[0] && m_full[1]) begin
      if (m_stamp[0] < m_stamp[1]) return 0;
      if (m_stamp[1] < m_stamp[0]) return 1;
`ifdef REGFILE_WB_RR_EN
      return (m_last_tie == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(input int i);
    if (reset) return 1'b0;
    return !m_full[i] || (m_winner() == i);
  endfunction

  always @(posedge CLK) begin
    int w;
    bit tie;
    bit acc [2];
    if (reset) begin
      m_live  = 1'b1;
      m_full  = '{1'b0, 1'b0};
      m_blk   = 1'b1;
      m_wa    = '0;
      m_wd    = '0;
`ifdef REGFILE_WB_RR_EN
      m_last_tie = 0;
`endif
    end else begin
      w      = m_winner();
      tie    = m_full[0] && m_full[1] && (m_stamp[0] == m_stamp[1]);
      acc[0] = bus.alu_valid && m_ready(0);
      acc[1] = bus.mem_valid && m_ready(1);
      if (w >= 0) begin
        m_blk          = 1'b0;
        m_wa           = m_addr[w];
        m_wd           = m_data[w];
        m_rf[m_addr[w]] = m_data[w];
        m_full[w]      = 1'b0;
`ifdef REGFILE_WB_RR_EN
        if (tie) m_last_tie = w;
`else
        if (tie) m_blk = 1'b0;
`endif
      end else begin
        m_blk = 1'b1;
      end
      if (acc[0]) begin
        m_full[0] = 1'b1; m_addr[0] = bus.alu_addr; m_data[0] = bus.alu_data; m_stamp[0] = m_cyc;
      end
      if (acc[1]) begin
        m_full[1] = 1'b1; m_addr[1] = bus.mem_addr; m_data[1] = bus.mem_data; m_stamp[1] = m_cyc;
      end
    end
    m_cyc++;
  end

  // Per-cycle compare, away from the active edge; also plays the register file.
  always @(negedge CLK) begin
    logic [7:0] pm;
    if (m_live) begin
      pm = '0;
      for (int i = 0; i < 2; i++) if (m_full[i]) pm[m_addr[i]] = 1'b1;
      if (!m_blk) pm[m_wa] = 1'b1;
      chk("alu_ready", 32'(bus.alu_ready), 32'(m_ready(0)));
      chk("mem_ready", 32'(bus.mem_ready), 32'(m_ready(1)));
      chk("WR_BLOCK",  32'(bus.WR_BLOCK),  32'(m_blk));
      chk("WR_ADDR",   32'(bus.WR_ADDR),   32'(m_wa));
      chk("WR_DATA",   32'(bus.WR_DATA),   32'(m_wd));
      chk("pend_mask", 32'(bus.pend_mask), 32'(pm));
    end
    if (bus.WR_BLOCK === 1'b0) tb_rf[bus.WR_ADDR] = bus.WR_DATA;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_rf[i]  = '0;
      tb_rf[i] = '0;
    end
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    tick();
    tick();
    chk("rst_WR_BLOCK", 32'(bus.WR_BLOCK), 1);
    chk("rst_WR_ADDR",  32'(bus.WR_ADDR),  0);
    chk("rst_pend",     32'(bus.pend_mask), 0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 0);

    // Reset with both slots full discards them.
    reset = 1'b0; bus.stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'd200;
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd4; bus.mem_data = 8'd100;
    tick();
    idle_inputs();
    chk("full_pend", 32'(bus.pend_mask), 32'h14);
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.stall = 1'b0;
    #1;
    chk("rst2_WR_BLOCK", 32'(bus.WR_BLOCK), 1);
    chk("rst2_pend", 32'(bus.pend_mask), 0);
    chk("rst2_alu_ready", 32'(bus.alu_ready), 1);
    chk("rst2_mem_ready", 32'(bus.mem_ready), 1);

    // Single ALU write.
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'd200;
    tick();
    idle_inputs();
    chk("single_pend0", 32'(bus.pend_mask), 32'h04);
    chk("single_blk0",  32'(bus.WR_BLOCK), 1);
    tick();
    chk("single_blk1",  32'(bus.WR_BLOCK), 0);
    chk("single_addr",  32'(bus.WR_ADDR), 2);
    chk("single_data",  32'(bus.WR_DATA), 200);
    chk("single_pend1", 32'(bus.pend_mask), 32'h04);
    tick();
    chk("single_blk2",  32'(bus.WR_BLOCK), 1);
    chk("single_pend2", 32'(bus.pend_mask), 0);
    chk("single_r2",    32'(tb_rf[2]), 200);

    // Different ages, same destination: program order.
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 8'd100;
    tick();
    idle_inputs();
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd4; bus.mem_data = 8'd33;
    tick();
    idle_inputs();
    chk("age_first_blk",  32'(bus.WR_BLOCK), 0);
    chk("age_first_data", 32'(bus.WR_DATA), 100);
    tick();
    chk("age_second_blk",  32'(bus.WR_BLOCK), 0);
    chk("age_second_data", 32'(bus.WR_DATA), 33);
    tick();
    chk("age_r4", 32'(tb_rf[4]), 33);

    // Two same-age ties.
    for (int t = 0; t < 2; t++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'd5;
      bus.mem_valid = 1'b1; bus.mem_addr = 3'd3; bus.mem_data = 8'd7;
      tick();
      idle_inputs();
      tick();
`ifdef REGFILE_WB_RR_EN
      chk("tie_first_addr", 32'(bus.WR_ADDR), (t == 0) ? 3 : 1);
      tick();
      chk("tie_second_addr", 32'(bus.WR_ADDR), (t == 0) ? 1 : 3);
`else
      chk("tie_first_addr", 32'(bus.WR_ADDR), 3);
      tick();
      chk("tie_second_addr", 32'(bus.WR_ADDR), 1);
`endif
      chk("tie_second_blk", 32'(bus.WR_BLOCK), 0);
      tick();
    end

    // Stall with both slots full.
    bus.stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd5; bus.alu_data = 8'd55;
    tick();
    idle_inputs();
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd6; bus.mem_data = 8'd66;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_alu_ready", 32'(bus.alu_ready), 0);
      chk("stall_mem_ready", 32'(bus.mem_ready), 0);
      tick();
      chk("stall_blk", 32'(bus.WR_BLOCK), 1);
    end
    bus.stall = 1'b0;
    tick();
    chk("drain1_addr", 32'(bus.WR_ADDR), 5);
    chk("drain1_data", 32'(bus.WR_DATA), 55);
    tick();
    chk("drain2_addr", 32'(bus.WR_ADDR), 6);
    chk("drain2_data", 32'(bus.WR_DATA), 66);
    tick();

    // Back-to-back ALU stream.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        bus.alu_valid = 1'b1; bus.alu_addr = 3'(i); bus.alu_data = 8'(10 + i);
        #1;
        chk("stream_ready", 32'(bus.alu_ready), 1);
      end else begin
        idle_inputs();
      end
      tick();
      if (i >= 1) begin
        chk("stream_blk",  32'(bus.WR_BLOCK), 0);
        chk("stream_addr", 32'(bus.WR_ADDR), i - 1);
      end
    end
    tick();
    for (int i = 0; i < 8; i++) chk("stream_rf", 32'(tb_rf[i]), 10 + i);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_addr  = 3'($urandom_range(0, 7));
      bus.alu_data  = 8'($urandom);
      bus.mem_valid = 1'($urandom_range(0, 1));
      bus.mem_addr  = 3'($urandom_range(0, 7));
      bus.mem_data  = 8'($urandom);
      tick();
    end
    reset = 1'b0; bus.stall = 1'b0;
    idle_inputs();
    repeat (4) tick();
    for (int i = 0; i < 8; i++) chk("final_rf", 32'(tb_rf[i]), 32'(m_rf[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
